fb_scanout: RTL and testbench

//  Single-clock framebuffer scanout engine; replaces the fixed two-bank PSRAM scanout path.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_line_fifo.sv | 44 ++++
 rtl/fb_scanout.sv | 186 ++++++++++++++++++
 tb/tb_fb_scanout.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and pixel helpers for the framebuffer scanout path.
package fb_pkg;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic {
    FMT_RGB565 = 1'b0,
    FMT_GREY8  = 1'b1
  } pix_fmt_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2
  } fetch_state_e;

  // Widen 5/6/5 channels to 8 bits by replicating the MSBs into the LSBs.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/fb_line_fifo.sv
// Line FIFO: 16-bit words, show-ahead head, flush drops all contents.
module fb_line_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [15:0]              wdata,
  output logic [15:0]              rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign do_push = push && (level != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush takes priority over push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: prefetch into line FIFO, emit RGB888 on external timing,
// vsync-synchronised buffer flips, underflow reporting.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int                WIDTH         = 267,
  parameter int                HEIGHT        = 240,
  parameter int                NUM_BUFFERS   = 2,
  parameter int                ADDR_W        = 22,
  parameter logic [ADDR_W-1:0] BUF_STRIDE    = 22'h20000,
  parameter int                FIFO_DEPTH    = 64,
  parameter logic [23:0]       UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              de,
  input  logic              vblank,
  input  logic              fmt_8bpp,
  input  logic              flip_req,
  output logic              flip_busy,
  output logic [1:0]        back_index,
  output logic [1:0]        front_index,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_busy,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic [23:0]       rgb,
  output logic              underflow,
  input  logic              underflow_clr
);
  localparam int TOT_565 = WIDTH * HEIGHT;
  localparam int TOT_8   = ((WIDTH + 1) / 2) * HEIGHT;
  localparam int WL_W    = $clog2(TOT_565 + 1);
  localparam int LV_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int COL_W   = $clog2(WIDTH);

  logic         vblank_q, frame_start;
  buf_idx_t     front, back, pending, front_n, back_n, pending_n;
  logic         pend_v, pend_v_n;

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [WL_W-1:0]   words_left;
  logic              discard;
  pix_fmt_e          fmt;

  logic              push, pop, empty, last_col, byte_hi, uf_now;
  logic [15:0]       rdata;
  logic [7:0]        grey;
  logic [LV_W-1:0]   level;
  logic [COL_W-1:0]  col;

  assign frame_start = vblank && !vblank_q;
  assign flip_busy   = pend_v;
  assign front_index = front;
  assign back_index  = back;
  assign mem_rd      = (state == F_REQ);
  assign mem_addr    = addr;

  fb_line_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (frame_start),
    .wdata (mem_rdata),
    .rdata (rdata),
    .empty (empty),
    .level (level)
  );

  // Buffer bookkeeping: apply pending flip at frame start first, then take a new request.
  always_comb begin
    front_n   = front;
    back_n    = back;
    pending_n = pending;
    pend_v_n  = pend_v;
    if (frame_start && pend_v) begin
      front_n  = pending;
      pend_v_n = 1'b0;
      if (NUM_BUFFERS == 2) back_n = front;
    end
    if (flip_req) begin
      if (!pend_v_n) begin
        pending_n = back_n;
        pend_v_n  = 1'b1;
        // Three indices sum to 3, so the free one is what remains.
        if (NUM_BUFFERS == 3) back_n = 2'd3 - front_n - back_n;
      end else if (NUM_BUFFERS == 3) begin
        pending_n = back_n;
        back_n    = pending;
      end
    end
  end

  // Buffer index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      front   <= 2'd0;
      back    <= 2'd1;
      pending <= 2'd0;
      pend_v  <= 1'b0;
    end else begin
      front   <= front_n;
      back    <= back_n;
      pending <= pending_n;
      pend_v  <= pend_v_n;
    end
  end

  // A response to a read from before the frame start, or arriving on it, is dropped.
  assign push = (state == F_WAIT) && mem_rvalid && !discard && !frame_start;

  // Fetch FSM next state: one outstanding read, only when the FIFO has room.
  always_comb begin
    state_n = state;
    unique case (state)
      F_IDLE: if (words_left != '0 && level < LV_W'(FIFO_DEPTH) && !mem_busy) state_n = F_REQ;
      F_REQ:  state_n = F_WAIT;
      F_WAIT: if (mem_rvalid) state_n = F_IDLE;
      default: state_n = F_IDLE;
    endcase
  end

  // Fetch state, address and word budget; frame start reloads from the new front buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= F_IDLE;
      vblank_q   <= 1'b0;
      addr       <= '0;
      words_left <= '0;
      discard    <= 1'b0;
      fmt        <= FMT_RGB565;
    end else begin
      state    <= state_n;
      vblank_q <= vblank;
      if (frame_start) begin
        addr       <= ADDR_W'(front_n) * BUF_STRIDE;
        fmt        <= fmt_8bpp ? FMT_GREY8 : FMT_RGB565;
        words_left <= fmt_8bpp ? WL_W'(TOT_8) : WL_W'(TOT_565);
        discard    <= (state == F_REQ) || (state == F_WAIT && !mem_rvalid);
      end else if (state == F_WAIT && mem_rvalid) begin
        if (discard) begin
          discard <= 1'b0;
        end else begin
          addr       <= addr + 1'b1;
          words_left <= words_left - 1'b1;
        end
      end
    end
  end

  // Grey8 words carry two pixels; the last pixel of an odd-width line also retires its word.
  assign last_col = (col == COL_W'(WIDTH - 1));
  assign uf_now   = pix_ce && de && empty;
  assign pop      = pix_ce && de && !empty && (fmt == FMT_RGB565 || byte_hi || last_col);
  assign grey     = byte_hi ? rdata[15:8] : rdata[7:0];

  // Pixel output register, line column/byte phase and sticky underflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= '0;
      underflow <= 1'b0;
      col       <= '0;
      byte_hi   <= 1'b0;
    end else begin
      underflow <= (underflow && !underflow_clr) || uf_now;
      if (frame_start) begin
        col     <= '0;
        byte_hi <= 1'b0;
      end else if (pix_ce && de) begin
        col     <= last_col ? '0 : col + 1'b1;
        byte_hi <= last_col ? 1'b0 : !byte_hi;
      end
      if (pix_ce) begin
        if (!de)                    rgb <= '0;
        else if (empty)             rgb <= UNDERFLOW_RGB;
        else if (fmt == FMT_RGB565) rgb <= rgb565_to_888(rdata);
        else                        rgb <= {grey, grey, grey};
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench: two scanout instances (2 and 3 buffers, even and odd width) on shared timing,
// each with its own memory responder, checked against a frame-level model.
`timescale 1ns/1ps
module tb_fb_scanout;
  localparam logic [21:0] STRIDE = 22'h20000;
  localparam logic [23:0] UF_RGB = 24'hFF00FF;

  logic clk = 1'b0;
  logic reset, pix_ce, vblank, fmt_8bpp, flip_req, underflow_clr;
  logic busy_rand, busy_force, busy_r, mem_busy;
  logic [1:0]  de, flip_busy, mem_rd, mem_rvalid, underflow;
  logic [1:0]  back_index [2];
  logic [1:0]  front_index [2];
  logic [21:0] mem_addr [2];
  logic [15:0] mem_rdata [2];
  logic [23:0] rgb [2];

  // memory responder state
  int          rcnt [2]     = '{0, 0};
  int          rd_cnt [2]   = '{0, 0};
  int          addr_bad [2] = '{0, 0};
  int          rd_start [2] = '{0, 0};
  int          force_lat    = 0;
  bit          addr_chk     = 1'b0;
  logic [21:0] first_addr [2];
  logic [15:0] rdata_q [2];
  bit          use_pat = 1'b0;
  logic [15:0] pat [4];

  // model state
  int          mfront [2], mback [2], mpend [2];
  bit          mpv [2];
  bit          mfmt;
  logic [21:0] mbase [2];
  logic [23:0] cap [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_busy = busy_rand ? busy_r : busy_force;
  always @(posedge clk) busy_r <= ($urandom_range(0, 3) == 0);

  function automatic int wd(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic int ht(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [15:0] memval(input logic [21:0] a);
    logic [15:0] hi;
    hi = 16'(a >> 17);
    return use_pat ? pat[a[1:0]] : (a[15:0] ^ (hi * 16'h3A5C));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fb_scanout #(
      .WIDTH(g == 0 ? 4 : 5), .HEIGHT(g == 0 ? 2 : 3), .NUM_BUFFERS(2 + g),
      .ADDR_W(22), .BUF_STRIDE(STRIDE), .FIFO_DEPTH(8), .UNDERFLOW_RGB(UF_RGB)
    ) dut (
      .clk(clk), .reset(reset), .pix_ce(pix_ce), .de(de[g]), .vblank(vblank),
      .fmt_8bpp(fmt_8bpp), .flip_req(flip_req), .flip_busy(flip_busy[g]),
      .back_index(back_index[g]), .front_index(front_index[g]),
      .mem_rd(mem_rd[g]), .mem_addr(mem_addr[g]), .mem_busy(mem_busy),
      .mem_rvalid(mem_rvalid[g]), .mem_rdata(mem_rdata[g]), .rgb(rgb[g]),
      .underflow(underflow[g]), .underflow_clr(underflow_clr)
    );

    assign mem_rvalid[g] = (rcnt[g] == 1);
    assign mem_rdata[g]  = rdata_q[g];

    // Memory: latency 1..3 (or forced), data is a fixed function of the address.
    always @(posedge clk) begin
      if (mem_rd[g]) begin
        rcnt[g]    <= (force_lat > 0) ? force_lat : int'($urandom_range(1, 3));
        rdata_q[g] <= memval(mem_addr[g]);
        rd_cnt[g]  <= rd_cnt[g] + 1;
        if (rd_cnt[g] == rd_start[g]) first_addr[g] <= mem_addr[g];
        if (addr_chk && mem_addr[g] != mbase[g] + 22'(rd_cnt[g] - rd_start[g]))
          addr_bad[g] <= addr_bad[g] + 1;
      end else if (rcnt[g] != 0) begin
        rcnt[g] <= rcnt[g] - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_flip(input int k);
    int t;
    if (!mpv[k]) begin
      mpend[k] = mback[k];
      mpv[k]   = 1'b1;
      if (k == 1)
        for (int i = 0; i < 3; i++)
          if (i != mfront[k] && i != mpend[k]) t = i;
      if (k == 1) mback[k] = t;
    end else if (k == 1) begin
      t        = mpend[k];
      mpend[k] = mback[k];
      mback[k] = t;
    end
  endfunction

  function automatic void m_apply(input int k);
    int of;
    if (mpv[k]) begin
      of        = mfront[k];
      mfront[k] = mpend[k];
      mpv[k]    = 1'b0;
      if (k == 0) mback[k] = of;
    end
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      mfront[k] = 0; mback[k] = 1; mpend[k] = 0; mpv[k] = 1'b0;
    end
  endfunction

  function automatic int words(input int k, input bit f8);
    return f8 ? ((wd(k) + 1) / 2) * ht(k) : wd(k) * ht(k);
  endfunction

  function automatic logic [23:0] exp_px(input int k, input int y, input int x);
    logic [15:0] w;
    logic [7:0]  r5, g6, b5, gy;
    int          wpl;
    if (!mfmt) begin
      w  = memval(mbase[k] + 22'(y * wd(k) + x));
      r5 = 8'(w >> 11);
      g6 = 8'((w >> 5) & 16'h3F);
      b5 = 8'(w & 16'h1F);
      return {(r5 << 3) | (r5 >> 2), (g6 << 2) | (g6 >> 4), (b5 << 3) | (b5 >> 2)};
    end
    wpl = (wd(k) + 1) / 2;
    w   = memval(mbase[k] + 22'(y * wpl + x / 2));
    gy  = (x % 2 == 1) ? 8'(w >> 8) : 8'(w & 16'hFF);
    return {gy, gy, gy};
  endfunction

  task automatic check_bufs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_front"}, 32'(front_index[k]), 32'(mfront[k]));
      chk({tag, "_back"}, 32'(back_index[k]), 32'(mback[k]));
      chk({tag, "_busy"}, 32'(flip_busy[k]), 32'(mpv[k]));
    end
    if (mpv[1]) chk({tag, "_distinct"}, 32'(back_index[1] != front_index[1] &&
                    back_index[1] != 2'(mpend[1])), 32'd1);
  endtask

  task automatic run_frame(input bit f8, input int nflip, input bit edge_flip, input bit stuck);
    fmt_8bpp   = f8;
    busy_rand  = !stuck;
    busy_force = stuck;
    addr_chk   = 1'b1;
    @(posedge clk); #1;
    vblank   = 1'b1;
    flip_req = edge_flip;
    mfmt     = f8;
    for (int k = 0; k < 2; k++) begin
      m_apply(k);
      mbase[k]    = 22'(mfront[k]) * STRIDE;
      rd_start[k] = rd_cnt[k];
      if (edge_flip) m_flip(k);
    end
    @(posedge clk); #1;
    flip_req = 1'b0;
    @(posedge clk); #1;
    check_bufs("fstart");
    repeat (48) @(posedge clk);
    #1 vblank = 1'b0;
    for (int i = 0; i < nflip; i++) begin
      @(posedge clk); #1 flip_req = 1'b1;
      @(posedge clk); #1 flip_req = 1'b0;
      for (int k = 0; k < 2; k++) m_flip(k);
      check_bufs("flip");
    end
    for (int y = 0; y < 3; y++) begin
      if (stuck && y == 1) busy_force = 1'b0;
      for (int x = 0; x < 7; x++) begin
        @(posedge clk); #1;
        pix_ce = 1'b1;
        for (int k = 0; k < 2; k++) de[k] = (x < wd(k) && y < ht(k));
        @(posedge clk); #1;
        pix_ce = 1'b0;
        de     = 2'b00;
        for (int k = 0; k < 2; k++) begin
          if (!stuck) begin
            chk("rgb", 32'(rgb[k]), (x < wd(k) && y < ht(k)) ? 32'(exp_px(k, y, x)) : 32'd0);
            if (x == 6) chk("no_uf", 32'(underflow[k]), 32'd0);
          end else if (y == 0 && x == 0) begin
            chk("uf_rgb", 32'(rgb[k]), 32'(UF_RGB));
          end
        end
        if (y == 0 && x < 2) cap[x] = rgb[0];
        repeat (6) @(posedge clk);
      end
    end
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("nreads", 32'(rd_cnt[k] - rd_start[k]), 32'(words(k, f8)));
      chk("first_addr", 32'(first_addr[k]), 32'(mbase[k]));
      chk("addr_seq", 32'(addr_bad[k]), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; pix_ce = 1'b0; de = 2'b00; vblank = 1'b0; fmt_8bpp = 1'b0;
    flip_req = 1'b0; underflow_clr = 1'b0; busy_rand = 1'b0; busy_force = 1'b0;
    pat[0] = 16'h0; pat[1] = 16'h0; pat[2] = 16'h0; pat[3] = 16'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rgb", 32'(rgb[k]), 32'd0);
      chk("rst_uf", 32'(underflow[k]), 32'd0);
      chk("rst_rd", 32'(mem_rd[k]), 32'd0);
    end
    check_bufs("rst");

    // plain 565 frame, memory returns the address
    run_frame(1'b0, 0, 1'b0, 1'b0);

    // known colours, two flips in one frame
    use_pat = 1'b1;
    pat[0] = 16'hF800; pat[1] = 16'h07E0; pat[2] = 16'h001F; pat[3] = 16'hFFFF;
    run_frame(1'b0, 2, 1'b0, 1'b0);
    chk("red", 32'(cap[0]), 32'hFF0000);
    chk("green", 32'(cap[1]), 32'h00FF00);

    // grey8 on the flipped buffers
    pat[0] = 16'h80FF; pat[1] = 16'h1234; pat[2] = 16'hA55A; pat[3] = 16'h00C3;
    run_frame(1'b1, 0, 1'b0, 1'b0);
    chk("grey_lo", 32'(cap[0]), 32'hFFFFFF);
    chk("grey_hi", 32'(cap[1]), 32'h808080);
    chk("nb2_front", 32'(front_index[0]), 32'd1);
    chk("nb2_back", 32'(back_index[0]), 32'd0);
    chk("nb2_base", 32'(first_addr[0]), 32'(STRIDE));
    chk("nb3_front", 32'(front_index[1]), 32'd2);
    use_pat = 1'b0;

    // memory stalled through the first line
    run_frame(1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) chk("uf_set", 32'(underflow[k]), 32'd1);
    repeat (5) @(posedge clk);
    #1 for (int k = 0; k < 2; k++) chk("uf_sticky", 32'(underflow[k]), 32'd1);
    underflow_clr = 1'b1;
    @(posedge clk); #1 underflow_clr = 1'b0;
    for (int k = 0; k < 2; k++) chk("uf_clr", 32'(underflow[k]), 32'd0);
    run_frame(1'b0, 1, 1'b0, 1'b0);

    // randomized frames
    for (int f = 0; f < 12; f++)
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0), 1'b0);

    // reset while a read is outstanding; the late response must be dropped
    force_lat = 10;
    addr_chk  = 1'b0;
    busy_rand = 1'b0; busy_force = 1'b0;
    @(posedge clk); #1 vblank = 1'b1;
    for (int i = 0; i < 20 && !mem_rd[0]; i++) @(negedge clk);
    chk("rd_seen", 32'(mem_rd[0]), 32'd1);
    @(posedge clk); #1;
    vblank = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mrst_rd", 32'(mem_rd[k]), 32'd0);
      chk("mrst_rgb", 32'(rgb[k]), 32'd0);
      chk("mrst_uf", 32'(underflow[k]), 32'd0);
    end
    check_bufs("mrst");
    // FIFO must be empty: a visible pixel underflows, and set beats clear
    pix_ce = 1'b1; de = 2'b11; underflow_clr = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0; de = 2'b00; underflow_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("mrst_empty", 32'(rgb[k]), 32'(UF_RGB));
      chk("uf_set_wins", 32'(underflow[k]), 32'd1);
    end
    force_lat = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
